// File: rtl/operand_collector.sv
// Operand collector: read-side front end of the 16x8 register file.
// Accepts one decoded instruction, waits out pending producers using a
// per-register scoreboard, captures both source operands (bypassing
// same-cycle writeback data) and holds them for execute behind valid/ready.
module operand_collector #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              issue_use_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   rs1_r, rs2_r, rd_r;
    logic                use_rs2_r;
    logic [NUM_REGS-1:0] scoreboard_r;
    logic [NUM_REGS-1:0] wb_mask_s, rd_mask_s, sb_eff_s, sb_next_s;
    logic                hazard_s, capture_s, accept_s, release_s;
    logic [DATA_W-1:0]   op1_s, op2_s;
    logic                out_valid_r, issue_ready_r;
    logic [DATA_W-1:0]   out_op1_r, out_op2_r;
    logic [ADDR_W-1:0]   out_rd_r;

    // Pending view for this cycle: a writeback landing now already clears its bit.
    always_comb begin
        wb_mask_s = '0;
        rd_mask_s = '0;
        if (wb_valid) begin
            wb_mask_s[wb_reg] = 1'b1;
        end else begin
            wb_mask_s = '0;
        end
        if (capture_s) begin
            rd_mask_s[rd_r] = 1'b1;
        end else begin
            rd_mask_s = '0;
        end
        sb_eff_s  = scoreboard_r & ~wb_mask_s;
        // Set after clear: a new producer of the same register stays outstanding.
        sb_next_s = sb_eff_s | rd_mask_s;
    end

    // Hazard detection, handshake events and operand selection with bypass.
    always_comb begin
        hazard_s  = sb_eff_s[rs1_r] | (use_rs2_r & sb_eff_s[rs2_r]);
        capture_s = (state_r == CHECK) && !hazard_s;
        accept_s  = (state_r == IDLE) && issue_valid;
        release_s = (state_r == HOLD) && out_ready;
        if (wb_valid && (wb_reg == rs1_r)) begin
            op1_s = wb_data;
        end else begin
            op1_s = read_data1;
        end
        if (!use_rs2_r) begin
            op2_s = '0;
        end else if (wb_valid && (wb_reg == rs2_r)) begin
            op2_s = wb_data;
        end else begin
            op2_s = read_data2;
        end
    end

    // Next-state logic for the IDLE -> CHECK -> HOLD sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CHECK;
                else          state_s = IDLE;
            end
            CHECK: begin
                if (capture_s) state_s = HOLD;
                else           state_s = CHECK;
            end
            HOLD: begin
                if (release_s) state_s = IDLE;
                else           state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latched instruction, scoreboard and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            rs1_r         <= '0;
            rs2_r         <= '0;
            rd_r          <= '0;
            use_rs2_r     <= 1'b0;
            scoreboard_r  <= '0;
            out_valid_r   <= 1'b0;
            issue_ready_r <= 1'b1;
            out_op1_r     <= '0;
            out_op2_r     <= '0;
            out_rd_r      <= '0;
        end else begin
            state_r       <= state_s;
            scoreboard_r  <= sb_next_s;
            out_valid_r   <= (state_s == HOLD);
            issue_ready_r <= (state_s == IDLE);
            if (accept_s) begin
                rs1_r     <= issue_rs1;
                rs2_r     <= issue_rs2;
                rd_r      <= issue_rd;
                use_rs2_r <= issue_use_rs2;
            end else begin
                rs1_r     <= rs1_r;
                rs2_r     <= rs2_r;
                rd_r      <= rd_r;
                use_rs2_r <= use_rs2_r;
            end
            if (capture_s) begin
                out_op1_r <= op1_s;
                out_op2_r <= op2_s;
                out_rd_r  <= rd_r;
            end else begin
                out_op1_r <= out_op1_r;
                out_op2_r <= out_op2_r;
                out_rd_r  <= out_rd_r;
            end
        end
    end

    assign issue_ready = issue_ready_r;
    assign out_valid   = out_valid_r;
    assign out_op1     = out_op1_r;
    assign out_op2     = out_op2_r;
    assign out_rd      = out_rd_r;
    assign read_reg1   = rs1_r;
    assign read_reg2   = rs2_r;

endmodule
